core_alu_wb: RTL

- Writeback stage directly downstream of core_alu in the EMC08 core.
- Holds the architectural ACC, B and PSW registers. Captures the ALU result and flags into them under control-unit command.
- Feeds CY/AC back to the ALU carry inputs and serves ACC/B/PSW on the internal SFR bus.
- Resolves same-cycle conflicts between ALU writeback, carry bit-ops and SFR writes.

---
 rtl/core_alu_wb.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/core_alu_wb.sv
// rtl/core_alu_wb.sv - EMC08 ALU writeback stage holding ACC, B and PSW
//
// Captures core_alu results and flags into the architectural ACC/B/PSW
// registers and arbitrates same-cycle conflicts between ALU writeback,
// carry bit-ops and SFR writes. Also serves ACC/B/PSW on the SFR bus.
//
// Optional feature macro: CORE_WB_SHADOW_EN (interrupt shadow of ACC/PSW).
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   wb_en_i              writeback strobe, one cycle per ALU op
//   wb_dest_i[1:0]       00 none, 01 ACC, 10 B, 11 ACC=lo and B=hi (MUL/DIV)
//   wb_flag_mask_i[2:0]  flag update enables {CY,AC,OV}
//   alu_result_i[15:0]   ALU result; alu_cy_i/alu_ac_i/alu_ov_i ALU flags
//   cy_op_i[1:0]         00 none, 01 CLR C, 10 SETB C, 11 CPL C
//   sfr_addr_i, sfr_wdata_i, sfr_wr_i, sfr_rd_i   SFR bus request
//   sfr_rdata_o, sfr_hit_o                        registered SFR read response
//   acc_o, b_o, psw_o    architectural registers, psw = {CY,AC,F0,RS1,RS0,OV,F1,P}
//   cy_o, ac_o           carry feedback to core_alu
//   rbank_o[1:0]         {RS1,RS0} register bank select
//   conflict_o           one-cycle pulse: an SFR write lost to a higher-priority update
//   irq_save_i, irq_restore_i   (CORE_WB_SHADOW_EN only) shadow save / restore

module core_alu_wb #(
  parameter logic [7:0] ACC_ADDR = 8'hE0,
  parameter logic [7:0] B_ADDR   = 8'hF0,
  parameter logic [7:0] PSW_ADDR = 8'hD0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_en_i,
  input  logic [1:0]  wb_dest_i,
  input  logic [2:0]  wb_flag_mask_i,
  input  logic [15:0] alu_result_i,
  input  logic        alu_cy_i,
  input  logic        alu_ac_i,
  input  logic        alu_ov_i,
  input  logic [1:0]  cy_op_i,
  input  logic [7:0]  sfr_addr_i,
  input  logic [7:0]  sfr_wdata_i,
  input  logic        sfr_wr_i,
  input  logic        sfr_rd_i,
`ifdef CORE_WB_SHADOW_EN
  input  logic        irq_save_i,
  input  logic        irq_restore_i,
`endif
  output logic [7:0]  sfr_rdata_o,
  output logic        sfr_hit_o,
  output logic [7:0]  acc_o,
  output logic [7:0]  b_o,
  output logic [7:0]  psw_o,
  output logic        cy_o,
  output logic        ac_o,
  output logic [1:0]  rbank_o,
  output logic        conflict_o
);

  // Architectural state. P is not stored: it is derived from ACC.
  logic [7:0] acc_q, b_q;
  logic       cy_q, ac_q, f0_q, rs1_q, rs0_q, ov_q, f1_q;
  logic [7:0] rdata_q;
  logic       hit_q;
  logic       conflict_q;

  // Next-state values
  logic [7:0] acc_d, b_d;
  logic       cy_d, ac_d, f0_d, rs1_d, rs0_d, ov_d, f1_d;
  logic [7:0] rdata_d;
  logic       hit_d;
  logic       conflict_d;

  // Request decode
  logic       sel_acc, sel_b, sel_psw, sel_any;
  logic       wr_acc, wr_b, wr_psw;
  logic       alu_acc, alu_b;
  logic [7:0] alu_b_val;
  logic       fl_cy, fl_ac, fl_ov;
  logic       cy_bitop;
  logic       parity;
  logic [7:0] psw_cur;
  logic [7:0] rd_val;

  // Bit 0 of an SFR write to PSW targets the read-only parity bit.
  logic       unused_wdata_p;
  assign unused_wdata_p = sfr_wdata_i[0];

  assign sel_acc = (sfr_addr_i == ACC_ADDR);
  assign sel_b   = (sfr_addr_i == B_ADDR);
  assign sel_psw = (sfr_addr_i == PSW_ADDR);
  assign sel_any = sel_acc | sel_b | sel_psw;

  assign wr_acc  = sfr_wr_i & sel_acc;
  assign wr_b    = sfr_wr_i & sel_b;
  assign wr_psw  = sfr_wr_i & sel_psw;

  // dest 01 and 11 both load ACC from the low byte; 10 and 11 both load B.
  assign alu_acc   = wb_en_i & wb_dest_i[0];
  assign alu_b     = wb_en_i & wb_dest_i[1];
  assign alu_b_val = wb_dest_i[0] ? alu_result_i[15:8] : alu_result_i[7:0];

  assign fl_cy    = wb_en_i & wb_flag_mask_i[2];
  assign fl_ac    = wb_en_i & wb_flag_mask_i[1];
  assign fl_ov    = wb_en_i & wb_flag_mask_i[0];
  assign cy_bitop = (cy_op_i != 2'b00);

  assign parity  = ^acc_q;
  assign psw_cur = {cy_q, ac_q, f0_q, rs1_q, rs0_q, ov_q, f1_q, parity};

`ifdef CORE_WB_SHADOW_EN
  logic [7:0] sh_acc_q;
  logic [6:0] sh_psw_q;   // PSW bits 7:1; P is recomputed from ACC
`endif

  // Register update arbitration: each target takes its highest-priority source.
  always_comb begin
    acc_d      = acc_q;
    b_d        = b_q;
    cy_d       = cy_q;
    ac_d       = ac_q;
    f0_d       = f0_q;
    rs1_d      = rs1_q;
    rs0_d      = rs0_q;
    ov_d       = ov_q;
    f1_d       = f1_q;
    conflict_d = 1'b0;

    if (alu_acc) begin
      acc_d = alu_result_i[7:0];
    end else if (wr_acc) begin
      acc_d = sfr_wdata_i;
    end

    if (alu_b) begin
      b_d = alu_b_val;
    end else if (wr_b) begin
      b_d = sfr_wdata_i;
    end

    if (fl_cy) begin
      cy_d = alu_cy_i;
    end else if (cy_bitop) begin
      case (cy_op_i)
        2'b01:   cy_d = 1'b0;
        2'b10:   cy_d = 1'b1;
        default: cy_d = ~cy_q;
      endcase
    end else if (wr_psw) begin
      cy_d = sfr_wdata_i[7];
    end

    if (fl_ac) begin
      ac_d = alu_ac_i;
    end else if (wr_psw) begin
      ac_d = sfr_wdata_i[6];
    end

    if (fl_ov) begin
      ov_d = alu_ov_i;
    end else if (wr_psw) begin
      ov_d = sfr_wdata_i[2];
    end

    if (wr_psw) begin
      f0_d  = sfr_wdata_i[5];
      rs1_d = sfr_wdata_i[4];
      rs0_d = sfr_wdata_i[3];
      f1_d  = sfr_wdata_i[1];
    end

    // A PSW write that loses any bit still lands its remaining bits above.
    conflict_d = (wr_acc & alu_acc)
               | (wr_b & alu_b)
               | (wr_psw & (fl_cy | cy_bitop | fl_ac | fl_ov));

`ifdef CORE_WB_SHADOW_EN
    // Restore overrides every ACC/PSW source, so any SFR write there is lost.
    if (irq_restore_i) begin
      acc_d = sh_acc_q;
      {cy_d, ac_d, f0_d, rs1_d, rs0_d, ov_d, f1_d} = sh_psw_q;
      conflict_d = conflict_d | wr_acc | wr_psw;
    end
`endif
  end

  // SFR read path: returns pre-edge values, so a same-cycle write is not seen.
  always_comb begin
    rd_val = 8'h00;
    if (sel_acc) begin
      rd_val = acc_q;
    end else if (sel_b) begin
      rd_val = b_q;
    end else if (sel_psw) begin
      rd_val = psw_cur;
    end
    hit_d   = sfr_rd_i & sel_any;
    rdata_d = hit_d ? rd_val : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= 8'h00;
      b_q        <= 8'h00;
      cy_q       <= 1'b0;
      ac_q       <= 1'b0;
      f0_q       <= 1'b0;
      rs1_q      <= 1'b0;
      rs0_q      <= 1'b0;
      ov_q       <= 1'b0;
      f1_q       <= 1'b0;
      rdata_q    <= 8'h00;
      hit_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      b_q        <= b_d;
      cy_q       <= cy_d;
      ac_q       <= ac_d;
      f0_q       <= f0_d;
      rs1_q      <= rs1_d;
      rs0_q      <= rs0_d;
      ov_q       <= ov_d;
      f1_q       <= f1_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef CORE_WB_SHADOW_EN
  // A simultaneous restore keeps the shadow intact so it is not clobbered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_acc_q <= 8'h00;
      sh_psw_q <= 7'h00;
    end else if (irq_save_i && !irq_restore_i) begin
      sh_acc_q <= acc_q;
      sh_psw_q <= psw_cur[7:1];
    end
  end
`endif

  assign acc_o       = acc_q;
  assign b_o         = b_q;
  assign psw_o       = psw_cur;
  assign cy_o        = cy_q;
  assign ac_o        = ac_q;
  assign rbank_o     = {rs1_q, rs0_q};
  assign sfr_rdata_o = rdata_q;
  assign sfr_hit_o   = hit_q;
  assign conflict_o  = conflict_q;

endmodule
